// File: rtl/edge_pkg.sv
// edge_pkg: shared state encodings and default timing constants for the debouncer and edge detector.
package edge_pkg;
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } db_state_e;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 16;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] chain_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= '0;
        else        chain_q <= {chain_q[STAGES-2:0], d_i};
    end
    assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a bouncing input and accepts a level only after DB_CYCLES equal samples.
module input_debouncer
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_raw,
    input  logic en,
    output logic sig_out,
    output logic sig_stable,
    output logic glitch
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    logic          sync_q;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          glitch_q, glitch_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sig_raw),
        .q_o   (sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= STABLE_LO;
            cnt_q    <= '0;
            out_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
        end
    end

    // cnt holds the number of target-level samples already taken in a PEND state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        glitch_d = 1'b0;
        if (!en) begin
            state_d = out_q ? STABLE_HI : STABLE_LO;
            cnt_d   = '0;
        end else begin
            case (state_q)
                PEND_HI, PEND_LO: begin
                    if (sync_q == (state_q == PEND_HI)) begin
                        if (cnt_q == LAST) begin
                            state_d = sync_q ? STABLE_HI : STABLE_LO;
                            out_d   = sync_q;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end else begin
                        state_d  = out_q ? STABLE_HI : STABLE_LO;
                        cnt_d    = '0;
                        glitch_d = 1'b1;
                    end
                end
                default: begin
                    if (sync_q != out_q) begin
                        if (DB_CYCLES == 1) begin
                            state_d = sync_q ? STABLE_HI : STABLE_LO;
                            out_d   = sync_q;
                        end else begin
                            state_d = sync_q ? PEND_HI : PEND_LO;
                            cnt_d   = ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign sig_out    = out_q;
    assign glitch     = glitch_q;
    assign sig_stable = (state_q == STABLE_LO) || (state_q == STABLE_HI);
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed stimulus on DB_CYCLES=4 and DB_CYCLES=1 instances, checked against a run-length model.
module tb_input_debouncer;
    logic clk = 1'b0;
    logic rst_n, sig_raw, en;
    logic out4, stable4, glitch4;
    logic out1, stable1, glitch1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_raw    (sig_raw),
        .en         (en),
        .sig_out    (out4),
        .sig_stable (stable4),
        .glitch     (glitch4)
    );

    input_debouncer #(.SYNC_STAGES(2), .DB_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_raw    (sig_raw),
        .en         (en),
        .sig_out    (out1),
        .sig_stable (stable1),
        .glitch     (glitch1)
    );

    // run = trailing count of enabled samples that differ from the accepted level
    typedef struct packed {
        int   run;
        logic out;
        logic gl;
        logic s0;
        logic s1;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t step(mdl_t m, logic raw, logic ena, int db);
        mdl_t n = m;
        n.gl = 1'b0;
        if (!ena) begin
            n.run = 0;
        end else if (m.s1 != m.out) begin
            n.run = m.run + 1;
            if (n.run == db) begin
                n.out = ~m.out;
                n.run = 0;
            end
        end else begin
            n.gl  = (m.run > 0);
            n.run = 0;
        end
        n.s1 = m.s0;
        n.s0 = raw;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= '0;
            m1 <= '0;
        end else begin
            m4 <= step(m4, sig_raw, en, 4);
            m1 <= step(m1, sig_raw, en, 1);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m4.sig_out",    out4,    m4.out);
        chk("m4.sig_stable", stable4, m4.run == 0);
        chk("m4.glitch",     glitch4, m4.gl);
        chk("m1.sig_out",    out1,    m1.out);
        chk("m1.sig_stable", stable1, m1.run == 0);
        chk("m1.glitch",     glitch1, m1.gl);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; sig_raw = 1'b0; en = 1'b1;
        #1;
        chk("rst.out",    out4,    1'b0);
        chk("rst.stable", stable4, 1'b1);
        chk("rst.glitch", glitch4, 1'b0);
        #10 rst_n = 1'b1;
        tick(3);
        // clean rising step
        sig_raw = 1'b1;
        tick(2); chk("step.E2.stable", stable4, 1'b1);
        tick(1); chk("step.E3.stable", stable4, 1'b0); chk("db1.E3.out", out1, 1'b1);
        tick(2); chk("step.E5.out", out4, 1'b0); chk("step.E5.stable", stable4, 1'b0);
        tick(1); chk("step.E6.out", out4, 1'b1); chk("step.E6.stable", stable4, 1'b1);
        chk("model.E6.out", m4.out, 1'b1);
        // clean release
        tick(2); sig_raw = 1'b0;
        tick(5); chk("rel.E5.out", out4, 1'b1);
        tick(1); chk("rel.E6.out", out4, 1'b0);
        // rising bounce: 1,1,0 then steady 1
        tick(2); sig_raw = 1'b1;
        tick(2); sig_raw = 1'b0;
        tick(1); sig_raw = 1'b1;
        tick(2); chk("bnc.E5.glitch", glitch4, 1'b1); chk("bnc.E5.out", out4, 1'b0);
        chk("model.E5.glitch", m4.gl, 1'b1);
        tick(1); chk("bnc.E6.glitch", glitch4, 1'b0); chk("bnc.E6.stable", stable4, 1'b0);
        tick(2); chk("bnc.E8.out", out4, 1'b0);
        tick(1); chk("bnc.E9.out", out4, 1'b1);
        // 3-cycle low pulse is rejected
        tick(2); sig_raw = 1'b0;
        tick(3); sig_raw = 1'b1;
        tick(2); chk("lp.E5.stable", stable4, 1'b0); chk("lp.E5.out", out4, 1'b1);
        tick(1); chk("lp.E6.glitch", glitch4, 1'b1); chk("lp.E6.out", out4, 1'b1);
        tick(1); chk("lp.E7.glitch", glitch4, 1'b0); chk("lp.E7.out", out4, 1'b1);
        // enable abort in PEND_HI with two samples taken
        tick(2); sig_raw = 1'b0;
        tick(8); chk("ea.low.out", out4, 1'b0);
        sig_raw = 1'b1;
        tick(4); chk("ea.E4.stable", stable4, 1'b0);
        en = 1'b0;
        tick(1); chk("ea.E5.stable", stable4, 1'b1); chk("ea.E5.glitch", glitch4, 1'b0);
        chk("ea.E5.out", out4, 1'b0);
        en = 1'b1;
        tick(3); chk("ea.E8.out", out4, 1'b0);
        tick(1); chk("ea.E9.out", out4, 1'b1);
        // asynchronous reset in PEND_LO
        tick(2); sig_raw = 1'b0;
        tick(4); chk("rm.E4.stable", stable4, 1'b0); chk("rm.E4.out", out4, 1'b1);
        sig_raw = 1'b1; rst_n = 1'b0;
        #1;
        chk("rm.async.out", out4, 1'b0);
        chk("rm.async.glitch", glitch4, 1'b0);
        chk("rm.async.stable", stable4, 1'b1);
        tick(1); rst_n = 1'b1;
        tick(5); chk("rm.E5.out", out4, 1'b0);
        tick(1); chk("rm.E6.out", out4, 1'b1);
        // single-cycle low pulse: DB_CYCLES=1 follows it, DB_CYCLES=4 rejects it
        tick(3); sig_raw = 1'b0;
        tick(1); sig_raw = 1'b1;
        tick(2); chk("db1.pulse.E3.out", out1, 1'b0); chk("db1.pulse.E3.glitch", glitch1, 1'b0);
        tick(1); chk("db1.pulse.E4.out", out1, 1'b1); chk("db1.pulse.E4.glitch", glitch1, 1'b0);
        chk("db4.pulse.E4.glitch", glitch4, 1'b1); chk("db4.pulse.E4.out", out4, 1'b1);
        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops; legal values are 2 or more.
REQ-002 SHALL have parameter DB_CYCLES, default 16: consecutive equal synchronized samples needed to accept a level change; legal values are 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sig_raw, input, 1 bit: asynchronous, possibly bouncing input (button, external pin).
REQ-006 SHALL have port en, input, 1 bit: debounce enable; when 0, any pending change is aborted.
REQ-007 SHALL have port sig_out, output, 1 bit: registered, debounced, clk-synchronous level; it is the sig_in source for the downstream edge detector.
REQ-008 SHALL have port sig_stable, output, 1 bit: 1 when no change is pending.
REQ-009 SHALL have port glitch, output, 1 bit: one-cycle pulse when a pending change is rejected.

Function
REQ-010 SHALL pass sig_raw through a SYNC_STAGES-deep flop chain; the last stage (sync_q) is the only signal the FSM samples.
REQ-011 SHALL implement states STABLE_LO, PEND_HI, STABLE_HI and PEND_LO, with an up-counter cnt of width clog2(DB_CYCLES+1).
REQ-012 STABLE_LO, sync_q=1, en=1: go to PEND_HI, cnt=1. STABLE_HI, sync_q=0, en=1: go to PEND_LO, cnt=1.
REQ-013 PEND_x, sample equals the target level: cnt increments. At the edge taking the DB_CYCLES-th consecutive sample: go to STABLE_x, toggle sig_out, cnt=0.
REQ-014 PEND_x, sample differs from the target: return to the previous STABLE state, cnt=0, sig_out unchanged, glitch=1 for exactly one cycle.
REQ-015 en=0 in any state: go to the STABLE state matching sig_out, cnt=0, glitch=0; the sync chain keeps running.
REQ-016 Latency: when sig_raw is first sampled high at edge E1 and stays high, sig_out SHALL be 1 after edge E(SYNC_STAGES+DB_CYCLES); the falling direction is symmetric.
REQ-017 DB_CYCLES=1: STABLE goes directly to the opposite STABLE on the first differing sample, no PEND state is entered, and glitch never asserts.
REQ-018 sig_stable SHALL be 1 exactly in STABLE_LO and STABLE_HI.
REQ-019 cnt SHALL never exceed DB_CYCLES and SHALL not wrap.
REQ-020 sig_out SHALL change at most once per clk cycle and only on a STABLE transition; glitch SHALL never coincide with a sig_out change.

Reset
REQ-021 rst_n low SHALL immediately clear the sync chain to 0, state to STABLE_LO, cnt to 0, sig_out to 0, glitch to 0, and set sig_stable to 1, regardless of clk.
REQ-022 Reset asserted mid-PEND SHALL discard the pending change without a glitch pulse.
REQ-023 If sig_raw is high at reset release, a normal rising acceptance SHALL follow after the REQ-016 latency, producing one downstream rising edge.

Structure
REQ-024 State encodings (2-bit) and the default SYNC_STAGES and DB_CYCLES values SHALL be defined as constants in shared package edge_pkg, which the edge detector also uses.
REQ-025 The synchronizer chain SHALL be a separate sub-module sync_ff, parameterized by stage count, with async active-low reset to 0; the FSM, counter and outputs stay in input_debouncer.

Verification
All scenarios use SYNC_STAGES=2, DB_CYCLES=4, en=1 unless stated.
REQ-026 Clean step: sig_raw 0->1 sampled at E1 -> sig_out=1 after E6, sig_stable=0 from E3 to E5, glitch never 1.
REQ-027 Bounce: sig_raw high for 2 cycles, low 1 cycle, then high steady -> exactly one glitch pulse, sig_out rises once, 6 edges after the final steady high is first sampled.
REQ-028 Release: after sig_out=1, sig_raw 1->0 -> sig_out=0 after 6 edges; a 3-cycle low pulse instead leaves sig_out=1 and gives one glitch.
REQ-029 Enable abort: en=0 during PEND_HI with cnt=2 -> next cycle state STABLE_LO, cnt=0, glitch=0; re-enabled with input still high -> full 4-sample count restarts.
REQ-030 Reset mid-operation: rst_n low in PEND_LO with sig_out=1 -> sig_out, glitch and cnt are 0 immediately and sig_stable=1; release with sig_raw=1 -> sig_out=1 6 edges later.
REQ-031 Boundary: DB_CYCLES=1 -> sig_out follows sig_raw with 3-edge latency; a 1-cycle pulse propagates and glitch stays 0.
